// File: rtl/btn_debounce_pkg.sv
// Shared types and width helpers for the button
// conditioning block.
`timescale 1ns/1ps
package btn_pkg;

  typedef enum logic [1:0] {
    REL,
    HELD,
    LONG
  } btn_state_t;

  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button pin / conditioned-event bundle between the
// board pins and the PL control logic.
`timescale 1ns/1ps
interface btn_debounce_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchronizer, stable-time
// debounce, press/release/long-press event FSM.
`timescale 1ns/1ps
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int LONG_CYCLES = 100_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);
  localparam int DW = cnt_w(DEB_CYCLES);
  localparam int HW = cnt_w(LONG_CYCLES);
  localparam logic [DW-1:0] DMAX =
    DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HMAX =
    HW'(LONG_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] dcnt_d;
  logic          lvl_q;
  btn_state_t    st_q;
  logic [HW-1:0] hcnt_q;
  logic          press_q;
  logic          rel_q;
  logic          long_q;
  logic          flip;
  logic          rise;
  logic          fall;

  assign flip = (s2_q != lvl_q) && (dcnt_q == DMAX);
  assign rise = flip & s2_q;
  assign fall = flip & ~s2_q;

  always_comb begin
    dcnt_d = dcnt_q + 1'b1;
    if ((s2_q == lvl_q) || flip) dcnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      dcnt_q <= '0;
      lvl_q  <= 1'b0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      dcnt_q <= dcnt_d;
      if (flip) lvl_q <= s2_q;
    end
  end

  // Strobes land on the same edge the level flips.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q    <= REL;
      hcnt_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      unique case (st_q)
        REL: begin
          if (rise) begin
            st_q    <= HELD;
            hcnt_q  <= '0;
            press_q <= 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            st_q  <= REL;
            rel_q <= 1'b1;
          end else if (hcnt_q == HMAX) begin
            st_q   <= LONG;
            long_q <= 1'b1;
          end else begin
            hcnt_q <= hcnt_q + 1'b1;
          end
        end
        LONG: begin
          if (fall) begin
            st_q  <= REL;
            rel_q <= 1'b1;
          end
        end
        default: st_q <= REL;
      endcase
    end
  end

  assign level_o   = lvl_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;
endmodule

// File: rtl/btn_debounce.sv
// Board button conditioner: polarity fix-up and one
// independent debounce channel per pin.
`timescale 1ns/1ps
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int LONG_CYCLES = 100_000_000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  btn_debounce_if.slave btn_if
);
  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] lvl;
  logic [N_BTN-1:0] prs;
  logic [N_BTN-1:0] rls;
  logic [N_BTN-1:0] lng;

  assign raw = btn_if.btn_raw ^ {N_BTN{ACTIVE_LOW}};

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk_i    (sys_clk),
      .rst_ni   (sys_rst_n),
      .raw_i    (raw[i]),
      .level_o  (lvl[i]),
      .press_o  (prs[i]),
      .release_o(rls[i]),
      .long_o   (lng[i])
    );
  end

  assign btn_if.btn_level   = lvl;
  assign btn_if.btn_press   = prs;
  assign btn_if.btn_release = rls;
  assign btn_if.btn_long    = lng;
endmodule
